fp_check_scoreboard: RTL

FP_CHECK_SCOREBOARD -- requirements
Module: fp_check_scoreboard

---
 rtl/fp_check_scoreboard.sv | 288 ++++++++++++++++++++++++++++
 1 files changed

// File: rtl/fp_check_scoreboard.sv
// fp_check_scoreboard
//   Self-checking scoreboard for an FPU under test. Test vectors (operands,
//   operation fields and the expected result/flags) are accepted on a
//   valid/ready handshake. Operands are forwarded to the FPU as a one-cycle
//   request, and the expectation is queued in an in-order FIFO. Each FPU
//   response pops the FIFO head. The comparison is registered for one cycle
//   before the pass/fail counters update.
//
//   Ports
//     clock_i, reset_ni            clock (rising edge), async active-low reset
//     start_i                      one-cycle pulse that begins a run
//     vec_valid_i/vec_ready_o      vector handshake, vec_last_i marks the final one
//     vec_data_i                   {data1,data2,data3,result,flags,fmt,rm,op,opcode}
//     dut_req_valid_o, dut_*_o     request strobe and fields to the FPU
//     dut_rsp_valid_i, dut_result_i, dut_flags_i   in-order FPU response
//     busy_o, done_o, failed_o     run status
//     rsp_err_o                    sticky: response arrived with nothing outstanding
//     pass_cnt_o, fail_cnt_o       saturating counters
//     fail_index_o, fail_result_o, fail_flags_o    capture of the first mismatch
module fp_check_scoreboard #(
   parameter int unsigned DEPTH        = 4,
   parameter bit          STOP_ON_FAIL = 1'b1,
   parameter bit          NAN_RELAX    = 1'b1
) (
   input  logic         clock_i,
   input  logic         reset_ni,
   input  logic         start_i,
   input  logic         vec_valid_i,
   output logic         vec_ready_o,
   input  logic         vec_last_i,
   input  logic [287:0] vec_data_i,
   output logic         dut_req_valid_o,
   output logic [63:0]  dut_data1_o,
   output logic [63:0]  dut_data2_o,
   output logic [63:0]  dut_data3_o,
   output logic [1:0]   dut_fmt_o,
   output logic [2:0]   dut_rm_o,
   output logic [1:0]   dut_op_o,
   output logic [9:0]   dut_opcode_o,
   input  logic         dut_rsp_valid_i,
   input  logic [63:0]  dut_result_i,
   input  logic [4:0]   dut_flags_i,
   output logic         busy_o,
   output logic         done_o,
   output logic         failed_o,
   output logic         rsp_err_o,
   output logic [31:0]  pass_cnt_o,
   output logic [31:0]  fail_cnt_o,
   output logic [31:0]  fail_index_o,
   output logic [63:0]  fail_result_o,
   output logic [4:0]   fail_flags_o
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW = $clog2(DEPTH + 1);

   typedef enum logic [2:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE, S_HALT} state_e;

   typedef struct packed {
      logic [63:0] result;
      logic [4:0]  flags;
      logic [1:0]  fmt;
      logic [9:0]  opcode;
      logic [31:0] index;
   } exp_t;

   state_e          state_q, state_d;
   exp_t            fifo_q [DEPTH];
   logic [AW-1:0]   wr_ptr_q, rd_ptr_q;
   logic [CW-1:0]   cnt_q;
   logic [31:0]     index_q;

   logic            cmp_vld_q;
   exp_t            cmp_exp_q;
   logic [63:0]     cmp_res_q;
   logic [4:0]      cmp_flg_q;

   logic            req_vld_q;
   logic [63:0]     data1_q, data2_q, data3_q;
   logic [1:0]      fmt_q;
   logic [2:0]      rm_q;
   logic [1:0]      op_q;
   logic [9:0]      opcode_q;

   logic [31:0]     pass_q, fail_q, fidx_q;
   logic [63:0]     fres_q;
   logic [4:0]      fflg_q;
   logic            failed_q, rsp_err_q;

   logic            active, accept, pop, orphan, start_ok, flush;
   logic            canon_nan, relax, res_match, match, halt;
   exp_t            push_entry;

   function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
      if (DEPTH == 1) return '0;
      return p + AW'(1);
   endfunction

   function automatic logic [31:0] sat_inc(input logic [31:0] c);
      return (c == 32'hFFFF_FFFF) ? c : c + 32'd1;
   endfunction

   // ---------------- handshake / event decode ----------------
   assign active   = (state_q == S_RUN) || (state_q == S_DRAIN);
   assign accept   = vec_valid_i & vec_ready_o;
   assign pop      = dut_rsp_valid_i & active & (cnt_q != '0);
   // Responses outside RUN/DRAIN (IDLE, DONE, HALT) are silently ignored.
   assign orphan   = dut_rsp_valid_i & active & (cnt_q == '0);
   assign start_ok = start_i & ~active;

   assign push_entry = '{result: vec_data_i[95:32], flags: vec_data_i[28:24],
                         fmt: vec_data_i[21:20], opcode: vec_data_i[9:0],
                         index: index_q};

   // ---------------- compare (on the registered response) ----------------
   // A canonical NaN from the FPU is accepted against any expected NaN whose
   // exponent and quiet bit agree, unless the opcode marks an exact-NaN op.
   always_comb begin
      canon_nan = (cmp_exp_q.fmt == 2'd0) ? (cmp_res_q[31:0] == 32'h7FC0_0000)
                                          : (cmp_res_q == 64'h7FF8_0000_0000_0000);
      relax     = NAN_RELAX & ~cmp_exp_q.opcode[9] & ~cmp_exp_q.opcode[6] & canon_nan;
      if (!relax)
         res_match = (cmp_exp_q.result == cmp_res_q);
      else if (cmp_exp_q.fmt == 2'd0)
         res_match = (cmp_exp_q.result[30:22] == cmp_res_q[30:22]);
      else
         res_match = (cmp_exp_q.result[62:51] == cmp_res_q[62:51]);
      match = res_match & (cmp_exp_q.flags == cmp_flg_q);
   end

   assign halt  = STOP_ON_FAIL & cmp_vld_q & ~match;
   assign flush = start_ok | halt;

   // ---------------- FSM: state register ----------------
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) state_q <= S_IDLE;
      else           state_q <= state_d;
   end

   // ---------------- FSM: next state ----------------
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         S_IDLE, S_DONE, S_HALT: if (start_i) state_d = S_RUN;
         S_RUN: begin
            if (halt)                     state_d = S_HALT;
            else if (accept & vec_last_i) state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Wait until every request is answered and its compare retired.
            if (halt) state_d = S_HALT;
            else if ((cnt_q == '0) && !cmp_vld_q && !dut_rsp_valid_i) state_d = S_DONE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   // ---------------- FSM: outputs ----------------
   always_comb begin
      busy_o      = active;
      done_o      = (state_q == S_DONE) & ~failed_q;
      vec_ready_o = (state_q == S_RUN) & (cnt_q < CW'(DEPTH));
   end

   // ---------------- expected-result FIFO ----------------
   always_ff @(posedge clock_i) begin
      if (accept) fifo_q[wr_ptr_q] <= push_entry;
   end

   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         index_q  <= '0;
      end else if (flush) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         cnt_q    <= '0;
         if (start_ok) index_q <= '0;
      end else begin
         if (accept) begin
            wr_ptr_q <= ptr_inc(wr_ptr_q);
            index_q  <= index_q + 32'd1;
         end
         if (pop) rd_ptr_q <= ptr_inc(rd_ptr_q);
         case ({accept, pop})
            2'b10:   cnt_q <= cnt_q + CW'(1);
            2'b01:   cnt_q <= cnt_q - CW'(1);
            default: cnt_q <= cnt_q;
         endcase
      end
   end

   // ---------------- FPU request register ----------------
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         req_vld_q <= 1'b0;
         data1_q   <= '0;
         data2_q   <= '0;
         data3_q   <= '0;
         fmt_q     <= '0;
         rm_q      <= '0;
         op_q      <= '0;
         opcode_q  <= '0;
      end else begin
         req_vld_q <= accept;
         if (accept) begin
            data1_q  <= vec_data_i[287:224];
            data2_q  <= vec_data_i[223:160];
            data3_q  <= vec_data_i[159:96];
            fmt_q    <= vec_data_i[21:20];
            rm_q     <= vec_data_i[18:16];
            op_q     <= vec_data_i[13:12];
            opcode_q <= vec_data_i[9:0];
         end
      end
   end

   // ---------------- compare stage ----------------
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         cmp_vld_q <= 1'b0;
         cmp_exp_q <= '0;
         cmp_res_q <= '0;
         cmp_flg_q <= '0;
      end else begin
         cmp_vld_q <= pop & ~flush;
         if (pop) begin
            cmp_exp_q <= fifo_q[rd_ptr_q];
            cmp_res_q <= dut_result_i;
            cmp_flg_q <= dut_flags_i;
         end
      end
   end

   // ---------------- result counters and first-failure capture ----------------
   always_ff @(posedge clock_i or negedge reset_ni) begin
      if (!reset_ni) begin
         pass_q    <= '0;
         fail_q    <= '0;
         fidx_q    <= '0;
         fres_q    <= '0;
         fflg_q    <= '0;
         failed_q  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else if (start_ok) begin
         pass_q    <= '0;
         fail_q    <= '0;
         fidx_q    <= '0;
         fres_q    <= '0;
         fflg_q    <= '0;
         failed_q  <= 1'b0;
         rsp_err_q <= 1'b0;
      end else begin
         if (orphan) rsp_err_q <= 1'b1;
         if (cmp_vld_q) begin
            if (match) pass_q <= sat_inc(pass_q);
            else begin
               fail_q   <= sat_inc(fail_q);
               failed_q <= 1'b1;
               if (!failed_q) begin
                  fidx_q <= cmp_exp_q.index;
                  fres_q <= cmp_res_q;
                  fflg_q <= cmp_flg_q;
               end
            end
         end
      end
   end

   assign dut_req_valid_o = req_vld_q;
   assign dut_data1_o     = data1_q;
   assign dut_data2_o     = data2_q;
   assign dut_data3_o     = data3_q;
   assign dut_fmt_o       = fmt_q;
   assign dut_rm_o        = rm_q;
   assign dut_op_o        = op_q;
   assign dut_opcode_o    = opcode_q;
   assign failed_o        = failed_q;
   assign rsp_err_o       = rsp_err_q;
   assign pass_cnt_o      = pass_q;
   assign fail_cnt_o      = fail_q;
   assign fail_index_o    = fidx_q;
   assign fail_result_o   = fres_q;
   assign fail_flags_o    = fflg_q;

endmodule
